// File: rtl/wb_trace_buffer_pkg.sv
// Shared definitions for the write-back trace buffer: record type tags and
// the packed trace record stored in each FIFO slot (type+pc+addr+data+be, 101 bits).
package wb_trace_buffer_pkg;

    typedef enum logic {
        TRC_GRF = 1'b0,
        TRC_DM  = 1'b1
    } trc_type_t;

    // Field order from MSB to LSB: type, pc, addr, data, be.
    typedef struct packed {
        trc_type_t   rec_type;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo_mem.sv
// Trace FIFO storage: DEPTH x 101-bit register array with one asynchronous
// read port. Write port 1 exists only when TRACE_DM_EN is defined.
module trace_fifo_mem
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we0,
    input  logic [AW-1:0] waddr0,
    input  trace_rec_t    wdata0,
`ifdef TRACE_DM_EN
    input  logic          we1,
    input  logic [AW-1:0] waddr1,
    input  trace_rec_t    wdata1,
`endif
    input  logic [AW-1:0] raddr,
    output trace_rec_t    rdata
);

    trace_rec_t mem [DEPTH];

    // Both ports target distinct slots when both are enabled, so ordering inside
    // the block does not matter; contents need no reset because the pointer
    // logic never exposes an unwritten slot.
    always_ff @(posedge clk) begin
        if (we0) begin
            mem[waddr0] <= wdata0;
        end
`ifdef TRACE_DM_EN
        if (we1) begin
            mem[waddr1] <= wdata1;
        end
`endif
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// Write-back trace buffer: captures GRF (W stage) and, with TRACE_DM_EN
// defined, DM (M stage) write events into an in-order show-ahead FIFO.
// Overflow drops events without stalling the core; drops are counted
// (saturating) and flagged sticky until reset.
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grf_we,
    input  logic [31:0]      grf_pc,
    input  logic [4:0]       grf_addr,
    input  logic [31:0]      grf_data,
    input  logic             dm_we,
    input  logic [31:0]      dm_pc,
    input  logic [31:0]      dm_addr,
    input  logic [31:0]      dm_data,
    input  logic [3:0]       dm_be,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_type,
    output logic [31:0]      out_pc,
    output logic [31:0]      out_addr,
    output logic [31:0]      out_data,
    output logic [3:0]       out_be,
    output logic             ovf,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = CNT_W + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] free_slots;
    logic          pop;
    logic          grf_acc;
    logic [1:0]    push_n;
    logic [1:0]    drop_n;
    logic [DW-1:0] drop_sum;
    trace_rec_t    grf_rec;
    trace_rec_t    head_rec;

    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    assign free_slots = CW'(DEPTH) - count + CW'(pop);
    assign grf_acc    = grf_we && (free_slots != '0);

    assign grf_rec = '{rec_type: TRC_GRF, pc: grf_pc, addr: {27'b0, grf_addr},
                       data: grf_data, be: 4'hF};

`ifdef TRACE_DM_EN
    logic       dm_acc;
    trace_rec_t dm_rec;

    // The DM event is younger than the GRF event, so it only gets a slot once
    // the GRF event (if any) has taken its own.
    assign dm_acc = dm_we && (free_slots > CW'(grf_acc));
    assign dm_rec = '{rec_type: TRC_DM, pc: dm_pc, addr: dm_addr, data: dm_data, be: dm_be};
    assign push_n = {1'b0, grf_acc} + {1'b0, dm_acc};
    assign drop_n = {1'b0, grf_we && !grf_acc} + {1'b0, dm_we && !dm_acc};
`else
    logic unused_dm;

    assign unused_dm = ^{dm_we, dm_pc, dm_addr, dm_data, dm_be};
    assign push_n    = {1'b0, grf_acc};
    assign drop_n    = {1'b0, grf_we && !grf_acc};
`endif

    assign drop_sum = {1'b0, drop_cnt} + DW'(drop_n);

    trace_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk    (clk),
        .we0    (grf_acc),
        .waddr0 (wr_ptr),
        .wdata0 (grf_rec),
`ifdef TRACE_DM_EN
        .we1    (dm_acc),
        .waddr1 (wr_ptr + AW'(grf_acc)),
        .wdata1 (dm_rec),
`endif
        .raddr  (rd_ptr),
        .rdata  (head_rec)
    );

    // Pointer, occupancy and overflow bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_n);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push_n) - CW'(pop);
            if (drop_n != 2'd0) begin
                ovf      <= 1'b1;
                drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            end
        end
    end

    assign out_type = out_valid ? head_rec.rec_type : TRC_GRF;
    assign out_pc   = out_valid ? head_rec.pc   : 32'h0;
    assign out_addr = out_valid ? head_rec.addr : 32'h0;
    assign out_data = out_valid ? head_rec.data : 32'h0;
    assign out_be   = out_valid ? head_rec.be   : 4'h0;

endmodule
